// File: rtl/bcd_stopwatch.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | bcd_stopwatch: parametrised BCD stopwatch with prescaler, load and lap   |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module bcd_stopwatch #(
  parameter int                DIGITS   = 4,
  parameter logic [DIGITS-1:0] SIX_MASK = 4'b0100,
  parameter int                PRESCALE = 1
) (
  input  logic                  clkin,
  input  logic                  clr,
  input  logic                  start_stop,
  input  logic                  lap,
  input  logic                  dir,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   cnt,
  output logic [4*DIGITS-1:0]   disp,
  output logic                  running,
  output logic                  lap_active,
  output logic                  cn
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]     presc;
  logic [4*DIGITS-1:0] held;
  logic [4*DIGITS-1:0] step_val;
  logic [4*DIGITS-1:0] clamp_val;
  logic [DIGITS:0]     chain;
  logic                tick;

  assign tick     = running && (presc == PS_MAX);
  assign chain[0] = 1'b1;

  // chain[i] is high when every digit below i sits at its roll point for
  // the current direction; chain[DIGITS] therefore marks a full-range wrap.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    localparam logic [3:0] DMAX = SIX_MASK[i] ? 4'd5 : 4'd9;
    logic [3:0] d;
    logic [3:0] ld;

    assign d  = cnt[4*i +: 4];
    assign ld = load_val[4*i +: 4];

    assign chain[i+1] = chain[i] & (dir ? (d == 4'd0) : (d == DMAX));

    assign step_val[4*i +: 4] = !chain[i] ? d :
                                dir       ? ((d == 4'd0) ? DMAX : d - 4'd1) :
                                            ((d == DMAX) ? 4'd0 : d + 4'd1);

    assign clamp_val[4*i +: 4] = (ld > DMAX) ? DMAX : ld;
  end

  always_ff @(posedge clkin) begin
    if (clr) begin
      cnt        <= '0;
      held       <= '0;
      presc      <= '0;
      running    <= 1'b0;
      lap_active <= 1'b0;
      cn         <= 1'b0;
    end else begin
      cn <= 1'b0;
      if (start_stop) begin
        running <= ~running;
      end
      // A load wins over a coincident tick and restarts the prescale period.
      if (load) begin
        cnt   <= clamp_val;
        presc <= '0;
      end else if (tick) begin
        cnt   <= step_val;
        presc <= '0;
        cn    <= chain[DIGITS];
      end else if (running) begin
        presc <= presc + 1'b1;
      end
      if (lap) begin
        if (!lap_active) begin
          held <= cnt;
        end
        lap_active <= ~lap_active;
      end
    end
  end

  assign disp = lap_active ? held : cnt;

endmodule
`default_nettype wire
